// File: rtl/mem_arb.sv
// Single-port RAM arbiter: data requester has priority, fetch is protected by a
// starvation counter; read data is returned with a strobe aligned to the RAM output.
module mem_arb #(
    parameter int A      = 8,
    parameter int D      = 16,
    parameter int STARVE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [A-1:0] i_addr,
    output logic         i_gnt,
    output logic         i_rvalid,
    output logic [D-1:0] i_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [A-1:0] d_addr,
    input  logic [D-1:0] d_wdata,
    output logic         d_gnt,
    output logic         d_rvalid,
    output logic [D-1:0] d_rdata,
    output logic         m_we,
    output logic [A-1:0] m_ad,
    output logic [D-1:0] m_idat,
    input  logic [D-1:0] m_dat
);

    localparam logic [3:0] SLIM = 4'(STARVE);

    logic [3:0] scnt;
    logic       i_rv_q;
    logic       d_rv_q;

    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (!rst) begin
            if (d_req && !(i_req && scnt == SLIM)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        m_we   = 1'b0;
        m_ad   = '0;
        m_idat = '0;
        if (d_gnt) begin
            m_we   = d_we;
            m_ad   = d_addr;
            m_idat = d_wdata;
        end else if (i_gnt) begin
            m_ad = i_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt   <= '0;
            i_rv_q <= 1'b0;
            d_rv_q <= 1'b0;
        end else begin
            i_rv_q <= i_gnt;
            d_rv_q <= d_gnt && !d_we;
            if (!i_req || i_gnt) begin
                scnt <= '0;
            end else if (d_gnt) begin
                scnt <= scnt + 4'd1;
            end
        end
    end

    // Masking with rst kills a read granted just before reset rose, within the same cycle.
    assign i_rvalid = i_rv_q & ~rst;
    assign d_rvalid = d_rv_q & ~rst;
    assign i_rdata  = m_dat;
    assign d_rdata  = m_dat;

endmodule
